eggtimer_ctrl: RTL and testbench

Sequencing controller for the egg-timer datapath. It holds the programmed duration, counts elapsed seconds on a 1 Hz tick, and runs the IDLE/RUN/PAUSE/DONE state machine. Its two 12-bit outputs (elapsed, programmed) drive the LED bar-graph display directly. The raised alarm is held until acknowledged.

---
 rtl/eggtimer_ctrl.sv | 132 +++++++++++++
 tb/tb_eggtimer_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/eggtimer_ctrl.sv
// Egg-timer sequencing controller: programmed duration, 1 Hz elapsed-second count,
// and the IDLE/RUN/PAUSE/DONE state machine driving the bar-graph outputs.
module eggtimer_ctrl #(
  parameter int unsigned CLK_HZ       = 100000000,
  parameter int unsigned PROG_STEP    = 10,
  parameter int unsigned PROG_MAX     = 4095,
  parameter int unsigned PROG_DEFAULT = 180
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_start,
  input  logic        btn_clear,
  input  logic        btn_up,
  input  logic        btn_down,
  output logic [11:0] timer_seconds,
  output logic [11:0] prog_seconds,
  output logic        running,
  output logic        alarm
);

  localparam int unsigned TW = 12;
  localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE,
    ST_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [TW-1:0]   timer_d, prog_d;
  logic [TW-1:0]   timer_inc_c;
  logic [TW:0]     prog_sum_c;

  // State register and registered outputs; flags decode the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      presc_q       <= '0;
      timer_seconds <= '0;
      prog_seconds  <= TW'(PROG_DEFAULT);
      running       <= 1'b0;
      alarm         <= 1'b0;
    end else begin
      state_q       <= state_d;
      presc_q       <= presc_d;
      timer_seconds <= timer_d;
      prog_seconds  <= prog_d;
      running       <= (state_d == ST_RUN);
      alarm         <= (state_d == ST_DONE);
    end
  end

  // Next-state, prescaler and counter update; clear beats start beats up/down
  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    timer_d     = timer_seconds;
    prog_d      = prog_seconds;
    timer_inc_c = timer_seconds + TW'(1);
    prog_sum_c  = (TW+1)'(prog_seconds) + (TW+1)'(PROG_STEP);

    case (state_q)
      ST_IDLE: begin
        if (btn_clear) begin
          timer_d = '0;
          presc_d = '0;
        end else if (btn_start) begin
          if (prog_seconds != '0) begin
            state_d = ST_RUN;
            timer_d = '0;
            presc_d = '0;
          end
        end else if (btn_up && !btn_down) begin
          prog_d = (prog_sum_c > (TW+1)'(PROG_MAX)) ? TW'(PROG_MAX) : prog_sum_c[TW-1:0];
        end else if (btn_down && !btn_up) begin
          prog_d = (prog_seconds >= TW'(PROG_STEP)) ? prog_seconds - TW'(PROG_STEP) : '0;
        end
      end

      ST_RUN: begin
        if (btn_clear) begin
          state_d = ST_IDLE;
          timer_d = '0;
          presc_d = '0;
        end else if (presc_q == PRESC_LAST) begin
          // Tick: the increment lands first; reaching the target beats a pause request
          presc_d = '0;
          timer_d = timer_inc_c;
          if (timer_inc_c == prog_seconds) begin
            state_d = ST_DONE;
          end else if (btn_start) begin
            state_d = ST_PAUSE;
          end
        end else begin
          presc_d = presc_q + PW'(1);
          if (btn_start) begin
            state_d = ST_PAUSE;
          end
        end
      end

      ST_PAUSE: begin
        if (btn_clear) begin
          state_d = ST_IDLE;
          timer_d = '0;
          presc_d = '0;
        end else if (btn_start) begin
          state_d = ST_RUN;
        end
      end

      ST_DONE: begin
        if (btn_clear) begin
          state_d = ST_IDLE;
          timer_d = '0;
          presc_d = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
        presc_d = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_eggtimer_ctrl.sv
// Self-checking bench for eggtimer_ctrl: directed scenarios plus random button
// traffic, all compared against a cycle-counting behavioural model.
module tb_eggtimer_ctrl;

  localparam int unsigned CLK_HZ       = 4;
  localparam int unsigned PROG_STEP    = 10;
  localparam int unsigned PROG_MAX     = 4095;
  localparam int unsigned PROG_DEFAULT = 180;

  logic        clk;
  logic        rst_n;
  logic        btn_start, btn_clear, btn_up, btn_down;
  logic [11:0] timer_seconds, prog_seconds;
  logic        running, alarm;

  int total_cnt;
  int bad_cnt;

  // Reference model: elapsed seconds derive from clocks spent running
  bit m_run, m_pause, m_done;
  int m_prog, m_elapsed, m_run_clks;

  eggtimer_ctrl #(
    .CLK_HZ      (CLK_HZ),
    .PROG_STEP   (PROG_STEP),
    .PROG_MAX    (PROG_MAX),
    .PROG_DEFAULT(PROG_DEFAULT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_start    (btn_start),
    .btn_clear    (btn_clear),
    .btn_up       (btn_up),
    .btn_down     (btn_down),
    .timer_seconds(timer_seconds),
    .prog_seconds (prog_seconds),
    .running      (running),
    .alarm        (alarm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    total_cnt++;
    if (got != exp) begin
      bad_cnt++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_pause = 0; m_done = 0;
    m_prog = PROG_DEFAULT; m_elapsed = 0; m_run_clks = 0;
  endtask

  task automatic model_edge(input bit s, input bit c, input bit u, input bit d);
    if (c) begin
      m_run = 0; m_pause = 0; m_done = 0;
      m_elapsed = 0; m_run_clks = 0;
    end else if (m_run) begin
      m_run_clks++;
      if (m_run_clks % CLK_HZ == 0) m_elapsed++;
      if (m_elapsed == m_prog) begin
        m_run = 0; m_done = 1;
      end else if (s) begin
        m_run = 0; m_pause = 1;
      end
    end else if (m_pause) begin
      if (s) begin
        m_pause = 0; m_run = 1;
      end
    end else if (!m_done) begin
      if (s) begin
        if (m_prog != 0) begin
          m_run = 1; m_elapsed = 0; m_run_clks = 0;
        end
      end else if (u && !d) begin
        m_prog = (m_prog + PROG_STEP > PROG_MAX) ? PROG_MAX : m_prog + PROG_STEP;
      end else if (d && !u) begin
        m_prog = (m_prog >= PROG_STEP) ? m_prog - PROG_STEP : 0;
      end
    end
  endtask

  task automatic compare_model();
    check("prog", prog_seconds, m_prog);
    check("timer", timer_seconds, m_elapsed);
    check("running", running, m_run);
    check("alarm", alarm, m_done);
  endtask

  // Called at posedge+1; presents buttons for one clock, then compares
  task automatic step(input bit s, input bit c, input bit u, input bit d);
    btn_start = s; btn_clear = c; btn_up = u; btn_down = d;
    @(posedge clk);
    model_edge(s, c, u, d);
    #1;
    btn_start = 0; btn_clear = 0; btn_up = 0; btn_down = 0;
    compare_model();
  endtask

  initial begin
    total_cnt = 0; bad_cnt = 0;
    btn_start = 0; btn_clear = 0; btn_up = 0; btn_down = 0;
    rst_n = 0;
    model_reset();
    #23 rst_n = 1;
    @(posedge clk); #1;
    check("rst_prog", prog_seconds, 180);
    check("rst_timer", timer_seconds, 0);
    check("rst_running", running, 0);
    check("rst_alarm", alarm, 0);

    // Programming: 3 up, 1 down
    repeat (3) step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    check("prog_200", prog_seconds, 200);
    step(0, 0, 1, 1);
    check("updown_same", prog_seconds, 200);

    // Clamp at the top
    repeat (389) step(0, 0, 1, 0);
    check("prog_4090", prog_seconds, 4090);
    step(0, 0, 1, 0);
    check("clamp_4095", prog_seconds, 4095);
    step(0, 0, 1, 0);
    check("clamp_hold", prog_seconds, 4095);

    // Down to 5, then run a full countdown to DONE
    repeat (409) step(0, 0, 0, 1);
    check("prog_5", prog_seconds, 5);
    step(1, 0, 0, 0);
    check("start_running", running, 1);
    for (int k = 1; k <= 5; k++) begin
      repeat (3) step(0, 0, 0, 0);
      check("pre_tick", timer_seconds, k - 1);
      step(0, 0, 0, 0);
      check("tick", timer_seconds, k);
    end
    check("done_running", running, 0);
    check("done_alarm", alarm, 1);
    repeat (20) step(1, 0, 1, 0);
    check("done_hold", timer_seconds, 5);
    check("done_alarm_hold", alarm, 1);
    step(0, 1, 0, 0);
    check("ack_timer", timer_seconds, 0);
    check("ack_alarm", alarm, 0);

    // Floor at zero; start with zero duration ignored
    step(0, 0, 0, 1);
    check("floor_0", prog_seconds, 0);
    step(1, 0, 0, 0);
    check("zero_start", running, 0);

    // Pause one clock after a tick, then resume
    step(0, 0, 1, 0);
    check("prog_10", prog_seconds, 10);
    step(1, 0, 0, 0);
    repeat (8) step(0, 0, 0, 0);
    check("run_2", timer_seconds, 2);
    step(1, 0, 0, 0);
    check("paused", running, 0);
    repeat (50) step(0, 0, 0, 0);
    check("pause_hold", timer_seconds, 2);
    step(1, 0, 0, 0);
    check("resumed", running, 1);
    repeat (2) step(0, 0, 0, 0);
    check("resume_pre", timer_seconds, 2);
    step(0, 0, 0, 0);
    check("resume_tick", timer_seconds, 3);

    // Clear beats start; up ignored while running
    step(1, 1, 0, 0);
    check("clr_start_timer", timer_seconds, 0);
    check("clr_start_run", running, 0);
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    check("run_prog_frozen", prog_seconds, 10);
    repeat (18) step(0, 0, 0, 0);
    check("run_5", timer_seconds, 5);

    // Asynchronous reset mid-run
    #3 rst_n = 0;
    #1;
    model_reset();
    check("arst_timer", timer_seconds, 0);
    check("arst_prog", prog_seconds, 180);
    check("arst_running", running, 0);
    check("arst_alarm", alarm, 0);
    #3 rst_n = 1;
    @(posedge clk); #1;
    repeat (12) step(0, 0, 0, 0);
    check("arst_no_resume", timer_seconds, 0);

    // Random button traffic
    for (int i = 0; i < 6000; i++) begin
      bit s, c, u, d;
      c = ($urandom_range(0, 99) < 1);
      s = ($urandom_range(0, 99) < 4);
      u = ($urandom_range(0, 99) < 10);
      d = ($urandom_range(0, 99) < 14);
      if (s) begin
        u = 0; d = 0;
      end
      step(s, c, u, d);
    end

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
